// File: rtl/fifo_sync_pkg.sv
// Shared sizing helpers and status types for the fifo_sync_gen2 family.
// Width functions take the depth as an argument so each instance sizes itself.
package fifo_sync_pkg;

    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    // Explicit wrap so non-power-of-two depths never index past the last entry.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic afull;
        logic aempty;
    } fifo_flags_t;

endpackage

// File: rtl/fifo_sync_mem.sv
// FIFO storage: DEPTH x WIDTH register array, one synchronous write port and
// one asynchronous read port. Contents are intentionally not reset.
module fifo_sync_mem #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PTR_W = 3
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [PTR_W-1:0] rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_sync_gen2.sv
// Parametrised single-clock FIFO with flush, almost-thresholds and occupancy count.
// Define FIFO_SYNC_FWFT_EN for first-word-fall-through reads; default is a registered read.
module fifo_sync_gen2
    import fifo_sync_pkg::*;
#(
    parameter int unsigned FIFO_WIDTH = 16,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned AFULL_LVL  = 6,
    parameter int unsigned AEMPTY_LVL = 1,
    localparam int unsigned CNT_W     = cnt_w(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [FIFO_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    output logic [FIFO_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  wr_ack,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  full,
    output logic                  empty,
    output logic                  almostfull,
    output logic                  almostempty,
    output logic [CNT_W-1:0]      count
);

    localparam int unsigned PTR_W = ptr_w(FIFO_DEPTH);

    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [FIFO_WIDTH-1:0] rd_data;
    logic                  rd_acc;
    logic                  wr_acc;
    logic                  rd_do;
    logic                  wr_do;
    fifo_flags_t           flags;

    always_comb begin
        flags        = '0;
        flags.empty  = (count == '0);
        flags.full   = (count == CNT_W'(FIFO_DEPTH));
        flags.afull  = (count >= CNT_W'(AFULL_LVL)) && !flags.full;
        flags.aempty = !flags.empty && (count <= CNT_W'(AEMPTY_LVL));
    end

    assign full        = flags.full;
    assign empty       = flags.empty;
    assign almostfull  = flags.afull;
    assign almostempty = flags.aempty;

    // A write at full is only taken when a read frees a slot in the same cycle.
    assign rd_acc = rd_en && !flags.empty;
    assign wr_acc = wr_en && (!flags.full || rd_acc);
    assign rd_do  = rd_acc && !flush;
    assign wr_do  = wr_acc && !flush;

    fifo_sync_mem #(
        .WIDTH (FIFO_WIDTH),
        .DEPTH (FIFO_DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_do),
        .wr_addr (wr_ptr),
        .wr_data (data_in),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_do) begin
                wr_ptr <= PTR_W'(ptr_inc(32'(wr_ptr), FIFO_DEPTH));
            end
            if (rd_do) begin
                rd_ptr <= PTR_W'(ptr_inc(32'(rd_ptr), FIFO_DEPTH));
            end
            unique case ({wr_do, rd_do})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ack    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            wr_ack    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wr_ack    <= wr_acc;
            overflow  <= wr_en && !wr_acc;
            underflow <= rd_en && !rd_acc;
        end
    end

`ifdef FIFO_SYNC_FWFT_EN
    assign data_out   = rd_data;
    assign data_valid = !flags.empty;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out   <= '0;
            data_valid <= 1'b0;
        end else if (rd_do) begin
            data_out   <= rd_data;
            data_valid <= 1'b1;
        end else begin
            data_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_sync_gen2.sv
// Directed self-checking bench for fifo_sync_gen2 at 16x8 with default thresholds.
// Covers the registered-read build, or the FWFT build when FIFO_SYNC_FWFT_EN is defined.
module tb_fifo_sync_gen2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        wr_en;
    logic [15:0] data_in;
    logic        rd_en;
    logic [15:0] data_out;
    logic        data_valid;
    logic        wr_ack;
    logic        overflow;
    logic        underflow;
    logic        full;
    logic        empty;
    logic        almostfull;
    logic        almostempty;
    logic [3:0]  count;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    fifo_sync_gen2 #(
        .FIFO_WIDTH (16),
        .FIFO_DEPTH (8),
        .AFULL_LVL  (6),
        .AEMPTY_LVL (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .wr_en       (wr_en),
        .data_in     (data_in),
        .rd_en       (rd_en),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .wr_ack      (wr_ack),
        .overflow    (overflow),
        .underflow   (underflow),
        .full        (full),
        .empty       (empty),
        .almostfull  (almostfull),
        .almostempty (almostempty),
        .count       (count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n   = 1'b0;
        flush   = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        data_in = '0;
        step();
        step();

        check_val("rst_count",  32'(count), 0);
        check_val("rst_empty",  32'(empty), 1);
        check_val("rst_full",   32'(full), 0);
        check_val("rst_afull",  32'(almostfull), 0);
        check_val("rst_aempty", 32'(almostempty), 0);
        check_val("rst_valid",  32'(data_valid), 0);
        check_val("rst_ack",    32'(wr_ack), 0);
        check_val("rst_ovf",    32'(overflow), 0);
        check_val("rst_unf",    32'(underflow), 0);
        rst_n = 1'b1;
        step();

`ifdef FIFO_SYNC_FWFT_EN
        wr_en = 1'b1; data_in = 16'h1234;
        step();
        wr_en = 1'b0;
        check_val("fwft_valid", 32'(data_valid), 1);
        check_val("fwft_data",  32'(data_out), 32'h1234);
        check_val("fwft_count", 32'(count), 1);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        check_val("fwft_pop_empty", 32'(empty), 1);
        check_val("fwft_pop_valid", 32'(data_valid), 0);
        check_val("fwft_pop_count", 32'(count), 0);
        for (int i = 1; i <= 3; i++) begin
            wr_en = 1'b1; data_in = 16'(i * 16'h0101);
            step();
        end
        wr_en = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            check_val("fwft_seq", 32'(data_out), 32'(i * 16'h0101));
            rd_en = 1'b1;
            step();
        end
        rd_en = 1'b0;
        check_val("fwft_seq_empty", 32'(empty), 1);
`else
        // fill to full, watching thresholds on the way
        for (int i = 1; i <= 8; i++) begin
            wr_en = 1'b1; data_in = 16'(i);
            step();
            check_val("fill_ack",    32'(wr_ack), 1);
            check_val("fill_count",  32'(count), 32'(i));
            check_val("fill_afull",  32'(almostfull), (i == 6 || i == 7) ? 1 : 0);
            check_val("fill_full",   32'(full), (i == 8) ? 1 : 0);
            check_val("fill_aempty", 32'(almostempty), (i == 1) ? 1 : 0);
            check_val("fill_empty",  32'(empty), 0);
        end

        data_in = 16'h0009;
        step();
        wr_en = 1'b0;
        check_val("ovf_pulse", 32'(overflow), 1);
        check_val("ovf_ack",   32'(wr_ack), 0);
        check_val("ovf_count", 32'(count), 8);
        step();
        check_val("ovf_clear", 32'(overflow), 0);

        wr_en = 1'b1; rd_en = 1'b1; data_in = 16'hAAAA;
        step();
        wr_en = 1'b0; rd_en = 1'b0;
        check_val("full_rw_ack",   32'(wr_ack), 1);
        check_val("full_rw_ovf",   32'(overflow), 0);
        check_val("full_rw_data",  32'(data_out), 32'h0001);
        check_val("full_rw_valid", 32'(data_valid), 1);
        check_val("full_rw_count", 32'(count), 8);
        step();
        check_val("hold_valid", 32'(data_valid), 0);
        check_val("hold_data",  32'(data_out), 32'h0001);

        // drain: 2..8 then the word written across the wrap
        for (int i = 2; i <= 9; i++) begin
            rd_en = 1'b1;
            step();
            check_val("drain_data",  32'(data_out), (i == 9) ? 32'hAAAA : 32'(i));
            check_val("drain_valid", 32'(data_valid), 1);
        end
        rd_en = 1'b0;
        check_val("drain_count", 32'(count), 0);
        check_val("drain_empty", 32'(empty), 1);
        step();

        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        check_val("unf_pulse", 32'(underflow), 1);
        check_val("unf_valid", 32'(data_valid), 0);
        step();
        check_val("unf_clear", 32'(underflow), 0);

        wr_en = 1'b1; rd_en = 1'b1; data_in = 16'h5555;
        step();
        wr_en = 1'b0; rd_en = 1'b0;
        check_val("emp_rw_ack",    32'(wr_ack), 1);
        check_val("emp_rw_unf",    32'(underflow), 1);
        check_val("emp_rw_count",  32'(count), 1);
        check_val("emp_rw_aempty", 32'(almostempty), 1);
        check_val("emp_rw_empty",  32'(empty), 0);
        check_val("emp_rw_valid",  32'(data_valid), 0);

        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; data_in = 16'(16'h0010 + i);
            step();
        end
        check_val("pre_flush_count", 32'(count), 5);
        flush = 1'b1; wr_en = 1'b1; data_in = 16'hBEEF;
        step();
        flush = 1'b0; wr_en = 1'b0;
        check_val("flush_count", 32'(count), 0);
        check_val("flush_empty", 32'(empty), 1);
        check_val("flush_ack",   32'(wr_ack), 0);
        check_val("flush_ovf",   32'(overflow), 0);
        check_val("flush_valid", 32'(data_valid), 0);

        wr_en = 1'b1; data_in = 16'h7777;
        step();
        wr_en = 1'b0;
        check_val("post_flush_empty", 32'(empty), 0);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        check_val("post_flush_data", 32'(data_out), 32'h7777);
        check_val("post_flush_cnt",  32'(count), 0);

        // async reset in the middle of a write
        wr_en = 1'b1; data_in = 16'h2222;
        step();
        data_in = 16'h3333;
        #2 rst_n = 1'b0;
        #1;
        check_val("mid_rst_count", 32'(count), 0);
        check_val("mid_rst_empty", 32'(empty), 1);
        check_val("mid_rst_ack",   32'(wr_ack), 0);
        step();
        wr_en = 1'b0;
        rst_n = 1'b1;
        step();
        check_val("after_rst_empty", 32'(empty), 1);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        check_val("after_rst_unf", 32'(underflow), 1);
        check_val("after_rst_cnt", 32'(count), 0);
`endif

        step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
